result_pack_multiplier_floating_point32: RTL and testbench

RESULT_PACK_MULTIPLIER_FLOATING_POINT32 -- requirements
Module: result_pack_multiplier_floating_point32

---
 rtl/result_pack_multiplier_floating_point32.sv | 148 ++++++++++++++
 tb/tb_result_pack_multiplier_floating_point32.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pack_multiplier_floating_point32.sv
// Two-stage FP32 multiplier back end: normalize the raw 24x24 product, then round, range-check and pack.
// Define ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module result_pack_multiplier_floating_point32 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [9:0]  exp_sum,
    input  logic [47:0] mant_prod,
    input  logic        zero_flag,
    input  logic        inf_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        ovf_flag,
    output logic        unf_flag
);

    logic               advance;

    logic               s1_valid_q,  s1_valid_d;
    logic               s1_sign_q,   s1_sign_d;
    logic signed [10:0] s1_exp_q,    s1_exp_d;
    logic [22:0]        s1_frac_q,   s1_frac_d;
    logic               s1_guard_q,  s1_guard_d;
    logic               s1_sticky_q, s1_sticky_d;
    logic               s1_zero_q,   s1_zero_d;
    logic               s1_inf_q,    s1_inf_d;

    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q,  out_data_d;
    logic               ovf_q,       ovf_d;
    logic               unf_q,       unf_d;

    logic               round_inc;
    logic [23:0]        frac_sum;
    logic signed [10:0] exp_fin;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf_flag  = ovf_q;
    assign unf_flag  = unf_q;

    // S1: normalize. The product of two [1,2) significands lies in [1,4), so at most one right shift.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_frac_d   = s1_frac_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_zero_d   = s1_zero_q;
        s1_inf_d    = s1_inf_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = sign_in;
                s1_zero_d = zero_flag;
                s1_inf_d  = inf_flag;
                if (mant_prod[47]) begin
                    s1_exp_d    = $signed({exp_sum[9], exp_sum}) + 11'sd1;
                    s1_frac_d   = mant_prod[46:24];
                    s1_guard_d  = mant_prod[23];
                    s1_sticky_d = |mant_prod[22:0];
                end else begin
                    s1_exp_d    = $signed({exp_sum[9], exp_sum});
                    s1_frac_d   = mant_prod[45:23];
                    s1_guard_d  = mant_prod[22];
                    s1_sticky_d = |mant_prod[21:0];
                end
            end
        end
    end

`ifdef ROUND_NEAREST_EN
    assign round_inc = s1_guard_q && (s1_sticky_q || s1_frac_q[0]);
`else
    logic unused_round_bits;
    assign unused_round_bits = s1_guard_q ^ s1_sticky_q;
    assign round_inc = 1'b0;
`endif

    // A carry out of the fraction leaves the low 23 bits at zero, which is the required result.
    assign frac_sum = {1'b0, s1_frac_q} + {23'd0, round_inc};
    assign exp_fin  = frac_sum[23] ? (s1_exp_q + 11'sd1) : s1_exp_q;

    // S2: special cases, range checks and pack.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                if (s1_zero_q) begin
                    out_data_d = 32'h0000_0000;
                end else if (s1_inf_q) begin
                    out_data_d = {s1_sign_q, 8'hFF, 23'h0};
                end else if (exp_fin >= 11'sd255) begin
                    out_data_d = {s1_sign_q, 8'hFF, 23'h0};
                    ovf_d      = 1'b1;
                end else if (exp_fin <= 11'sd0) begin
                    out_data_d = {s1_sign_q, 31'h0};
                    unf_d      = 1'b1;
                end else begin
                    out_data_d = {s1_sign_q, exp_fin[7:0], frac_sum[22:0]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 11'sd0;
            s1_frac_q   <= 23'h0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_frac_q   <= s1_frac_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_zero_q   <= s1_zero_d;
            s1_inf_q    <= s1_inf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

endmodule

// File: tb/tb_result_pack_multiplier_floating_point32.sv
// Bench for the FP32 multiplier pack stage: expected {ovf,unf,data} words are queued at
// input handshake and compared in order when results leave the DUT.
module tb_result_pack_multiplier_floating_point32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_sum = 10'd0;
    logic [47:0] mant_prod = 48'd0;
    logic        zero_flag = 1'b0;
    logic        inf_flag = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        ovf_flag;
    logic        unf_flag;

    int tests_run = 0;
    int fails = 0;
    logic [33:0] exp_q[$];
    logic rand_rdy = 1'b0;

    result_pack_multiplier_floating_point32 dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_sum(exp_sum), .mant_prod(mant_prod),
        .zero_flag(zero_flag), .inf_flag(inf_flag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Reference model, written as shift-and-compare on the 24-bit remainder.
    function automatic logic [33:0] model(input logic s, input logic [9:0] e, input logic [47:0] m,
                                          input logic z, input logic i);
        logic [47:0] mn;
        logic [23:0] f;
        logic [23:0] rem;
        logic        up;
        int          ex;
        if (z) return 34'h0;
        if (i) return {2'b00, s, 8'hFF, 23'h0};
        ex = int'($signed(e));
        if (m[47]) ex = ex + 1;
        mn  = m[47] ? m : (m << 1);
        f   = {1'b0, mn[46:24]};
        rem = mn[23:0];
        up  = 1'b0;
`ifdef ROUND_NEAREST_EN
        up = (rem > 24'h80_0000) || ((rem == 24'h80_0000) && f[0]);
`endif
        f = f + {23'd0, up};
        if (f[23]) begin
            ex = ex + 1;
            f  = 24'd0;
        end
        if (ex >= 255) return {2'b10, s, 8'hFF, 23'h0};
        if (ex <= 0)   return {2'b01, s, 31'h0};
        return {2'b00, s, ex[7:0], f[22:0]};
    endfunction

    // Output scoreboard plus hold-stability check while stalled.
    logic [33:0] hold_word;
    logic        was_stalled = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            was_stalled = 1'b0;
        end else begin
            if (was_stalled) begin
                tests_run++;
                if (!out_valid || {ovf_flag, unf_flag, out_data} !== hold_word) begin
                    fails++;
                    $display("FAIL hold_stable: got valid=%0b word=%h, want valid=1 word=%h",
                             out_valid, {ovf_flag, unf_flag, out_data}, hold_word);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got word=%h, want no output",
                             {ovf_flag, unf_flag, out_data});
                end else begin
                    logic [33:0] want;
                    want = exp_q.pop_front();
                    if ({ovf_flag, unf_flag, out_data} !== want) begin
                        fails++;
                        $display("FAIL result: got ovf=%0b unf=%0b data=%h, want ovf=%0b unf=%0b data=%h",
                                 ovf_flag, unf_flag, out_data, want[33], want[32], want[31:0]);
                    end
                end
            end
            was_stalled = out_valid && !out_ready;
            hold_word   = {ovf_flag, unf_flag, out_data};
        end
    end

    // Called between posedge+1 and the next negedge; returns at posedge+1 after the handshake.
    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic z, input logic i, input logic [33:0] want);
        int n = 0;
        sign_in = s; exp_sum = e; mant_prod = m; zero_flag = z; inf_flag = i;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests_run++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, want 1");
        end else begin
            exp_q.push_back(want);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0b d=%h o=%0b u=%0b, want 0 0 0 0",
                     out_valid, out_data, ovf_flag, unf_flag);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        send(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0000});
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: got out_valid=%0b one cycle after accept, want 0", out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000) begin
            fails++;
            $display("FAIL latency: got v=%0b d=%h two cycles after accept, want v=1 d=3f800000",
                     out_valid, out_data);
        end
        wait_drain();
    endtask

    task automatic test_directed();
        send(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h4010_0000});
        send(1'b1, 10'd255, 48'h4000_0000_0000, 1'b0, 1'b0, {2'b10, 32'hFF80_0000});
        send(1'b1, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, {2'b01, 32'h8000_0000});
        send(1'b0, 10'd254, 48'h4000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h7F00_0000});
        send(1'b0, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, {2'b10, 32'h7F80_0000});
        send(1'b0, 10'd1,   48'h4000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h0080_0000});
        send(1'b0, 10'd0,   48'h8000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h0080_0000});
        send(1'b0, 10'h3FF, 48'h8000_0000_0000, 1'b0, 1'b0, {2'b01, 32'h0000_0000});
        send(1'b1, 10'h300, 48'hC000_0000_0000, 1'b0, 1'b0, {2'b01, 32'h8000_0000});
        wait_drain();
    endtask

    task automatic test_special();
        send(1'b1, 10'd255, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1, {2'b00, 32'h0000_0000});
        send(1'b0, 10'h3FF, 48'h1234_5678_9ABC, 1'b1, 1'b0, {2'b00, 32'h0000_0000});
        send(1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b1, {2'b00, 32'hFF80_0000});
        send(1'b0, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b1, {2'b00, 32'h7F80_0000});
        wait_drain();
    endtask

    task automatic test_rounding();
`ifdef ROUND_NEAREST_EN
        send(1'b0, 10'd127, 48'h4000_0060_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0001});
        send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, {2'b00, 32'h4000_0000});
        send(1'b0, 10'd254, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, {2'b10, 32'h7F80_0000});
        send(1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0000});
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0002});
`else
        send(1'b0, 10'd127, 48'h4000_0060_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0000});
        send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, {2'b00, 32'h3FFF_FFFF});
        send(1'b0, 10'd254, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, {2'b00, 32'h7F7F_FFFF});
        send(1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0000});
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0001});
`endif
        wait_drain();
    endtask

    task automatic test_stall();
        logic [31:0] held;
        out_ready = 1'b0;
        send(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0000});
        send(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h4010_0000});
        sign_in = 1'b1; exp_sum = 10'd128; mant_prod = 48'h4000_0000_0000;
        zero_flag = 1'b0; inf_flag = 1'b0; in_valid = 1'b1;
        held = 32'h3F80_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                fails++;
                $display("FAIL stall: got in_ready=%0b v=%0b d=%h, want 0 1 %h",
                         in_ready, out_valid, out_data, held);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b1, 10'd128, 48'h4000_0000_0000, 1'b0, 1'b0, {2'b00, 32'hC000_0000});
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        logic [47:0] m;
        logic [9:0]  e;
        logic        s;
        for (int k = 0; k < 12; k++) begin
            r = {$urandom, $urandom};
            m = r[47:0];
            m[47] = k[0];
            m[46] = 1'b1;
            e = 10'($urandom_range(100, 160));
            s = 1'($urandom_range(0, 1));
            send(s, e, m, 1'b0, 1'b0, model(s, e, m, 1'b0, 1'b0));
        end
        wait_drain();
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [47:0] m;
        logic [9:0]  e;
        logic        s, z, i;
        rand_rdy = 1'b1;
        for (int k = 0; k < 60; k++) begin
            r = {$urandom, $urandom};
            m = r[47:0];
            if (!m[47]) m[46] = 1'b1;
            e = 10'($urandom_range(0, 1023));
            s = 1'($urandom_range(0, 1));
            z = ($urandom_range(0, 7) == 0);
            i = ($urandom_range(0, 7) == 0);
            send(s, e, m, z, i, model(s, e, m, z, i));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        send(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h3F80_0000});
        send(1'b0, 10'd128, 48'h4000_0000_0000, 1'b0, 1'b0, {2'b00, 32'h4000_0000});
        rstn = 1'b0;
        exp_q.delete();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin
            fails++;
            $display("FAIL midstream_reset: got v=%0b d=%h o=%0b u=%0b, want 0 0 0 0",
                     out_valid, out_data, ovf_flag, unf_flag);
        end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stale_output: got v=%0b in_ready=%0b after reset, want 0 1",
                         out_valid, in_ready);
            end
        end
        @(posedge clk);
        #1;
        send(1'b1, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, {2'b00, 32'hC010_0000});
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_special();
        test_rounding();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d queued results, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by time limit, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
